// File: rtl/data_mem_store_buffer_pkg.sv
// data_mem_store_buffer_pkg: shared widths, store-entry layout and word-index helper.
package data_mem_store_buffer_pkg;
    localparam int DATA_W = 32;
    localparam int BYTE_OFS = 2;
    localparam int IDX_W = DATA_W - BYTE_OFS;
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } store_entry_t;
    // Word index with bits above the array width cleared so entry compares stay exact.
    function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_W-1:0] a, input int aw);
        return IDX_W'(a >> BYTE_OFS) & ~({IDX_W{1'b1}} << aw);
    endfunction
endpackage

// File: rtl/data_mem_store_buffer_store_fifo.sv
// data_mem_store_buffer_store_fifo: circular store buffer exposing every entry for forwarding.
module data_mem_store_buffer_store_fifo
    import data_mem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  store_entry_t push_entry,
    input  logic         pop,
    output logic [PW-1:0] head,
    output logic [CW-1:0] count,
    output store_entry_t ents [DEPTH]
);
    logic [PW-1:0] tail;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ents  <= '{default: '0};
        end else begin
            // When full, pop and push hit the same slot; the push assignment wins.
            if (pop) ents[head].valid <= 1'b0;
            if (push) ents[tail] <= push_entry;
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/data_mem_store_buffer.sv
// data_mem_store_buffer: word RAM behind a store buffer, with same-cycle load forwarding
// and a preload port that outranks the drain on the single write port.
module data_mem_store_buffer
    import data_mem_store_buffer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_mem_read_address,
    input  logic [DATA_W-1:0] data_mem_write_address,
    input  logic [DATA_W-1:0] data_mem_write_data,
    input  logic              mem_write,
    output logic [DATA_W-1:0] data_mem_out,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [CW-1:0]     buf_count,
    output logic              buf_empty
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [PW-1:0] head;
    store_entry_t ents [DEPTH];
    store_entry_t head_e;
    logic ld_acc, drain;
    logic [IDX_W-1:0] rd_idx;
    assign ld_ready  = buf_count != CW'(DEPTH);
    assign buf_empty = buf_count == '0;
    assign ld_acc    = ld_valid && ld_ready;
    assign drain     = !ld_acc && !buf_empty;
    assign head_e    = ents[head];
    assign rd_idx    = word_idx(data_mem_read_address, ADDR_W);
    data_mem_store_buffer_store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_write),
        .push_entry('{valid: 1'b1, idx: word_idx(data_mem_write_address, ADDR_W), data: data_mem_write_data}),
        .pop       (drain),
        .head      (head),
        .count     (buf_count),
        .ents      (ents)
    );
    always_ff @(posedge clk) begin
        if (ld_acc) mem[ld_addr] <= ld_data;
        else if (drain) mem[ADDR_W'(head_e.idx)] <= head_e.data;
    end
    // Walk oldest to newest so the latest matching entry overrides earlier ones.
    always_comb begin
        data_mem_out = mem[ADDR_W'(rd_idx)];
        for (int k = 0; k < DEPTH; k++) begin
            if (ents[head + PW'(k)].valid && ents[head + PW'(k)].idx == rd_idx)
                data_mem_out = ents[head + PW'(k)].data;
        end
    end
endmodule
